// File: rtl/fir_mac_sequencer_if.sv
// Handshake and memory-port bundle between the FIR MAC sequencer and its caller / CMEM / IMEM.
interface fir_mac_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
);
  logic              start;
  logic [ADDR_W-1:0] base_ptr;
  logic              busy;
  logic              coef_rd_en;
  logic [ADDR_W-1:0] coef_addr;
  logic [DATA_W-1:0] coef_data;
  logic              samp_rd_en;
  logic [ADDR_W-1:0] samp_addr;
  logic [DATA_W-1:0] samp_data;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic              sat;
  logic [ACC_W-1:0]  acc_out;

  modport slave (
    input  start, base_ptr, coef_data, samp_data,
    output busy, coef_rd_en, coef_addr, samp_rd_en, samp_addr,
           result, result_valid, sat, acc_out
  );

  modport master (
    output start, base_ptr, coef_data, samp_data,
    input  busy, coef_rd_en, coef_addr, samp_rd_en, samp_addr,
           result, result_valid, sat, acc_out
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Walks all taps once per start, MACs CMEM x circular IMEM pairs into a wide accumulator,
// and emits one saturated DATA_W result with a single-cycle valid strobe.
module fir_mac_sequencer #(
  parameter int NUM_TAPS = 64,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int SHIFT    = 0
) (
  input logic                rclk,
  input logic                resetn,
  fir_mac_sequencer_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);
  localparam logic signed [ACC_W-1:0] RES_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RES_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                    state_q;
  logic                      rd_en_q;
  logic [ADDR_W-1:0]         coef_addr_q;
  logic [ADDR_W-1:0]         samp_addr_q;
  logic                      busy_q;
  logic [DATA_W-1:0]         result_q;
  logic                      sat_q;
  logic                      rv_q;
  logic [STAGES:1]           vld_pipe_q;
  logic signed [PROD_W-1:0]  prod_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_shr;
  logic [DATA_W-1:0]         result_d;
  logic                      sat_d;
  logic                      accept;

  assign accept  = (state_q == IDLE) && bus.start;
  assign acc_shr = acc_q >>> SHIFT;

  always_comb begin
    result_d = acc_shr[DATA_W-1:0];
    sat_d    = 1'b0;
    if (acc_shr > RES_MAX) begin
      result_d = RES_MAX[DATA_W-1:0];
      sat_d    = 1'b1;
    end else if (acc_shr < RES_MIN) begin
      result_d = RES_MIN[DATA_W-1:0];
      sat_d    = 1'b1;
    end
  end

  // The sample address is seeded from base_ptr and walks backwards, wrapping naturally.
  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      coef_addr_q <= '0;
      samp_addr_q <= '0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q     <= ISSUE;
            busy_q      <= 1'b1;
            rd_en_q     <= 1'b1;
            coef_addr_q <= '0;
            samp_addr_q <= bus.base_ptr;
          end
        end
        ISSUE: begin
          if (coef_addr_q == LAST_TAP) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            coef_addr_q <= coef_addr_q + ADDR_W'(1);
            samp_addr_q <= samp_addr_q - ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Final product is being accumulated on this edge when only the last stage is live.
          if (vld_pipe_q[STAGES] && !vld_pipe_q[1]) state_q <= DONE;
        end
        DONE: begin
          result_q <= result_d;
          sat_q    <= sat_d;
          rv_q     <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // vld_pipe_q[1]: memory data valid; vld_pipe_q[2]: registered product valid.
  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe_q <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], rd_en_q};
      if (vld_pipe_q[1])
        prod_q <= PROD_W'($signed(bus.coef_data)) * PROD_W'($signed(bus.samp_data));
      if (accept)
        acc_q <= '0;
      else if (vld_pipe_q[STAGES])
        acc_q <= acc_q + ACC_W'(prod_q);
    end
  end

  assign bus.busy         = busy_q;
  assign bus.coef_rd_en   = rd_en_q;
  assign bus.samp_rd_en   = rd_en_q;
  assign bus.coef_addr    = coef_addr_q;
  assign bus.samp_addr    = samp_addr_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign bus.sat          = sat_q;
  assign bus.acc_out      = acc_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed vector table, random runs against a sum-of-products
// model, and hand sequences for re-start, held start and mid-run reset.
module tb_fir_mac_sequencer;
  localparam int NT = 64;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int AC = 40;
  localparam int SH = 0;
  localparam int LAT = NT + 3;

  logic rclk = 1'b0;
  logic resetn = 1'b1;
  always #5 rclk = ~rclk;

  fir_mac_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .ACC_W(AC)) bus();
  fir_mac_sequencer #(.NUM_TAPS(NT), .ADDR_W(AW), .DATA_W(DW), .ACC_W(AC), .SHIFT(SH))
    dut (.rclk(rclk), .resetn(resetn), .bus(bus));

  logic signed [DW-1:0] cmem [NT];
  logic signed [DW-1:0] imem [NT];

  always @(posedge rclk) begin
    if (bus.coef_rd_en) bus.coef_data <= cmem[bus.coef_addr];
    if (bus.samp_rd_en) bus.samp_data <= imem[bus.samp_addr];
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int     mode;
    int     base;
    longint exp_res;
    longint exp_sat;
    longint exp_acc;
  } vec_t;

  task automatic load(input int mode);
    for (int k = 0; k < NT; k++) begin
      case (mode)
        0: begin cmem[k] = 16'(5);      imem[k] = 16'(5); end
        1: begin cmem[k] = 16'(k);      imem[k] = (k == 61) ? 16'(100) : 16'(0); end
        2: begin cmem[k] = 16'(k);      imem[k] = (k == 2)  ? 16'(100) : 16'(0); end
        3: begin cmem[k] = 16'(32767);  imem[k] = 16'(32767); end
        4: begin cmem[k] = 16'(-32768); imem[k] = 16'(32767); end
        default: begin cmem[k] = (k % 2 == 0) ? 16'(1) : 16'(-1); imem[k] = 16'(1000); end
      endcase
    end
  endtask

  // Direct convolution over the circular sample buffer.
  task automatic model(input int base, output longint acc, output longint res, output longint s);
    longint v;
    acc = 0;
    for (int k = 0; k < NT; k++)
      acc += longint'(cmem[k]) * longint'(imem[((base - k) % NT + NT) % NT]);
    acc = (acc <<< (64 - AC)) >>> (64 - AC);
    v = acc >>> SH;
    if (v > 32767) begin res = 32767; s = 1; end
    else if (v < -32768) begin res = -32768; s = 1; end
    else begin res = v; s = 0; end
  endtask

  task automatic run(input int base, input int repulse, input bit trace,
                     output longint r, output longint s, output longint a,
                     output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    @(negedge rclk);
    bus.start = 1'b1;
    bus.base_ptr = AW'(base);
    @(negedge rclk);
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge rclk);
      bus.start = (cyc == repulse);
      if (bus.busy) busy_cnt++;
      if (trace && cyc < LAT) begin
        chk("coef_rd_en", longint'(bus.coef_rd_en), (cyc < NT) ? 1 : 0);
        chk("samp_rd_en", longint'(bus.samp_rd_en), (cyc < NT) ? 1 : 0);
        if (cyc < NT) begin
          chk("coef_addr", longint'(bus.coef_addr), cyc);
          chk("samp_addr", longint'(bus.samp_addr), ((base - cyc) % NT + NT) % NT);
        end
      end
      if (bus.result_valid) begin
        lat = cyc;
        break;
      end
    end
    bus.start = 1'b0;
    r = longint'($signed(bus.result));
    s = longint'(bus.sat);
    a = longint'($signed(bus.acc_out));
  endtask

  task automatic count_valids(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge rclk);
      if (bus.result_valid) n++;
    end
  endtask

  initial begin
    vec_t   vt [6];
    longint r, s, a, er, es, ea;
    int     lat, bc, n;
    int     tv [3];

    vt[0] = '{0, 0,  1600,   0, 1600};
    vt[1] = '{1, 0,  300,    0, 300};
    vt[2] = '{2, 5,  300,    0, 300};
    vt[3] = '{3, 0,  32767,  1, 64'sd68715282496};
    vt[4] = '{4, 0, -32768,  1, -64'sd68717379584};
    vt[5] = '{5, 3,  0,      0, 0};

    bus.start = 1'b0;
    bus.base_ptr = '0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_busy",   longint'(bus.busy), 0);
    chk("rst_result", longint'(bus.result), 0);
    chk("rst_valid",  longint'(bus.result_valid), 0);
    chk("rst_sat",    longint'(bus.sat), 0);
    chk("rst_acc",    longint'(bus.acc_out), 0);
    chk("rst_rd_en",  longint'(bus.coef_rd_en | bus.samp_rd_en), 0);
    chk("rst_addr",   longint'({bus.coef_addr, bus.samp_addr}), 0);
    repeat (3) @(negedge rclk);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load(vt[i].mode);
      run(vt[i].base, -1, vt[i].mode == 5, r, s, a, lat, bc);
      chk($sformatf("v%0d_result", i), r, vt[i].exp_res);
      chk($sformatf("v%0d_sat", i), s, vt[i].exp_sat);
      chk($sformatf("v%0d_acc", i), a, vt[i].exp_acc);
      chk($sformatf("v%0d_latency", i), lat, LAT);
      chk($sformatf("v%0d_busy_cycles", i), bc, LAT);
      @(negedge rclk);
      chk($sformatf("v%0d_valid_drop", i), longint'(bus.result_valid), 0);
      chk($sformatf("v%0d_result_hold", i), longint'($signed(bus.result)), vt[i].exp_res);
    end

    for (int t = 0; t < 6; t++) begin
      int b;
      for (int k = 0; k < NT; k++) begin
        if (t % 2 == 1) begin
          cmem[k] = DW'($urandom);
          imem[k] = DW'($urandom);
        end else begin
          cmem[k] = DW'(int'($urandom_range(400)) - 200);
          imem[k] = DW'(int'($urandom_range(400)) - 200);
        end
      end
      b = int'($urandom_range(NT - 1));
      model(b, ea, er, es);
      run(b, -1, 1'b0, r, s, a, lat, bc);
      chk($sformatf("rnd%0d_result", t), r, er);
      chk($sformatf("rnd%0d_sat", t), s, es);
      chk($sformatf("rnd%0d_acc", t), a, ea);
      chk($sformatf("rnd%0d_latency", t), lat, LAT);
    end

    // start re-pulsed mid-run must not queue a second run
    load(0);
    run(0, 10, 1'b0, r, s, a, lat, bc);
    chk("repulse_result", r, 1600);
    chk("repulse_latency", lat, LAT);
    count_valids(90, n);
    chk("repulse_extra_valids", n, 0);

    // start held high: one result every NT+4 cycles
    @(negedge rclk);
    bus.start = 1'b1;
    bus.base_ptr = '0;
    n = 0;
    for (int cyc = 0; cyc < 300 && n < 3; cyc++) begin
      @(negedge rclk);
      if (bus.result_valid) begin
        tv[n] = cyc;
        n++;
        chk("held_result", longint'($signed(bus.result)), 1600);
      end
    end
    chk("held_count", n, 3);
    if (n == 3) begin
      chk("held_period1", tv[1] - tv[0], NT + 4);
      chk("held_period2", tv[2] - tv[1], NT + 4);
    end
    bus.start = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 100 && bus.busy; cyc++) @(negedge rclk);
    chk("held_idle", longint'(bus.busy), 0);
    @(negedge rclk);

    // reset dropped at tap 30 aborts the run
    @(negedge rclk);
    bus.start = 1'b1;
    @(negedge rclk);
    bus.start = 1'b0;
    repeat (30) @(negedge rclk);
    #2 resetn = 1'b0;
    #1;
    chk("abort_busy",   longint'(bus.busy), 0);
    chk("abort_result", longint'(bus.result), 0);
    chk("abort_acc",    longint'(bus.acc_out), 0);
    chk("abort_rd_en",  longint'(bus.coef_rd_en | bus.samp_rd_en), 0);
    chk("abort_addr",   longint'({bus.coef_addr, bus.samp_addr}), 0);
    chk("abort_valid",  longint'(bus.result_valid), 0);
    repeat (2) @(negedge rclk);
    resetn = 1'b1;
    count_valids(80, n);
    chk("abort_no_valid", n, 0);
    run(0, -1, 1'b0, r, s, a, lat, bc);
    chk("post_reset_result", r, 1600);
    chk("post_reset_sat", s, 0);
    chk("post_reset_acc", a, 1600);
    chk("post_reset_latency", lat, LAT);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
